// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Multiply/divide unit for the E stage of the pipelined MIPS core. Owns the
// HI/LO registers. MULT/DIV results are computed at the accept edge and held
// in pending registers. They are committed to HI/LO when the busy down-counter
// expires. The result is visible on the first cycle with Busy=0.
//
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (codes 0111-1010). When the macro is undefined these codes are no-ops.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   Start     E-stage instruction requests an MD operation
//   MDUOP     operation code
//   Time      busy cycles for this op; 0 selects the parameter default
//   Req       exception/interrupt flush; blocks acceptance of the E-stage op
//   A, B      forwarded rs / rt operands
//   ReadHILO  01 = read HI, 10 = read LO, other = read 0
//   Busy      multi-cycle operation in progress
//   HILOOut   combinational HI/LO read data
//   HI, LO    committed HI/LO registers
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOP,
    input  logic [3:0]  Time,
    input  logic        Req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  ReadHILO,
    output logic        Busy,
    output logic [31:0] HILOOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b0111;
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MSUB  = 4'b1001;
    localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        accept;
    logic [3:0]  mul_n, div_n;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        div_ovf;

    assign accept = Start & ~Req & (cnt_q == 4'd0);
    assign mul_n  = (Time != 4'd0) ? Time : MULT_N;
    assign div_n  = (Time != 4'd0) ? Time : DIV_N;

    // Operands are sign/zero-extended to 64 bits so that the truncated 64-bit
    // product is the exact full-width result.
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // The most-negative / -1 quotient overflows 32 bits. Pin it to the MIPS
    // result instead of relying on simulator or synthesis behaviour.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    always_comb begin
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (B != 32'd0) begin
            quo_u = A / B;
            rem_u = A % B;
            if (div_ovf) begin
                quo_s = 32'h8000_0000;
                rem_s = 32'd0;
            end else begin
                quo_s = $signed(A) / $signed(B);
                rem_s = $signed(A) % $signed(B);
            end
        end
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        cnt_d     = cnt_q;
        if (cnt_q != 4'd0) begin
            // In flight: Req is ignored here because the op is already committed.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d = hi_pend_q;
                lo_d = lo_pend_q;
            end
        end else if (accept) begin
            case (MDUOP)
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                OP_MULT: begin
                    {hi_pend_d, lo_pend_d} = prod_s;
                    cnt_d = mul_n;
                end
                OP_MULTU: begin
                    {hi_pend_d, lo_pend_d} = prod_u;
                    cnt_d = mul_n;
                end
                OP_DIV: begin
                    if (B != 32'd0) begin
                        hi_pend_d = rem_s;
                        lo_pend_d = quo_s;
                        cnt_d     = div_n;
                    end
                end
                OP_DIVU: begin
                    if (B != 32'd0) begin
                        hi_pend_d = rem_u;
                        lo_pend_d = quo_u;
                        cnt_d     = div_n;
                    end
                end
`ifdef MDU_MADD_EN
                OP_MADD: begin
                    {hi_pend_d, lo_pend_d} = {hi_q, lo_q} + prod_s;
                    cnt_d = mul_n;
                end
                OP_MADDU: begin
                    {hi_pend_d, lo_pend_d} = {hi_q, lo_q} + prod_u;
                    cnt_d = mul_n;
                end
                OP_MSUB: begin
                    {hi_pend_d, lo_pend_d} = {hi_q, lo_q} - prod_s;
                    cnt_d = mul_n;
                end
                OP_MSUBU: begin
                    {hi_pend_d, lo_pend_d} = {hi_q, lo_q} - prod_u;
                    cnt_d = mul_n;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            hi_pend_q <= '0;
            lo_pend_q <= '0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Busy = (cnt_q != 4'd0);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        case (ReadHILO)
            2'b01:   HILOOut = hi_q;
            2'b10:   HILOOut = lo_q;
            default: HILOOut = 32'd0;
        endcase
    end

endmodule
